// File: rtl/mem_stage_nb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_nb : non-blocking MEM stage, in-order load return queue to WB    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module mem_stage_nb #(
  parameter int DEPTH = 2,
  parameter int PL_W  = 87
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            es_to_ms_valid,
  output logic            ms_allowin,
  input  logic [31:0]     es_pc,
  input  logic [31:0]     es_result,
  input  logic            es_rf_we,
  input  logic [4:0]      es_rf_waddr,
  input  logic            es_res_from_mem,
  input  logic            es_mem_req,
  input  logic [4:0]      es_ld_op,
  input  logic [PL_W-1:0] es_pl,
  output logic            ms_req_allow,
  input  logic [4:0]      ds_rj,
  input  logic [4:0]      ds_rk,
  output logic            ms_ld_hazard,
  input  logic            data_sram_data_ok,
  input  logic [31:0]     data_sram_rdata,
  input  logic            wb_ex,
  output logic            ms_to_ws_valid,
  input  logic            ws_allowin,
  output logic [31:0]     ms_pc,
  output logic            ms_rf_we,
  output logic [4:0]      ms_rf_waddr,
  output logic [31:0]     ms_rf_wdata,
  output logic [PL_W-1:0] ms_pl
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_cancel_cnt;

  logic            r_valid        [DEPTH];
  logic [31:0]     r_pc           [DEPTH];
  logic [31:0]     r_result       [DEPTH];
  logic            r_rf_we        [DEPTH];
  logic [4:0]      r_waddr        [DEPTH];
  logic            r_res_from_mem [DEPTH];
  logic            r_mem_req      [DEPTH];
  logic [4:0]      r_ld_op        [DEPTH];
  logic [PL_W-1:0] r_pl           [DEPTH];
  logic            r_data_got     [DEPTH];
  logic [31:0]     r_rdata        [DEPTH];

  logic [AW-1:0]   w_head;
  logic [AW-1:0]   w_tail;
  logic [AW-1:0]   w_scan_idx;
  logic [AW-1:0]   w_resp_idx;
  logic            w_resp_hit;
  logic [PW-1:0]   w_live_pend;
  logic            w_route;
  logic            w_resp_to_head;
  logic            w_head_ready;
  logic            w_full;
  logic            w_deq;
  logic            w_enq;
  logic            w_cancel_dec;
  logic [PW:0]     w_cancel_sum;
  logic [PW-1:0]   w_cancel_flush;
  logic [31:0]     w_head_rdata;
  logic [31:0]     w_shift;
  logic [31:0]     w_ext;

  assign w_head = r_rd_ptr[AW-1:0];
  assign w_tail = r_wr_ptr[AW-1:0];

  // Oldest live entry still waiting for data; scanning from the youngest
  // slot down lets the oldest match overwrite the others.
  always_comb begin
    w_resp_hit = 1'b0;
    w_resp_idx = '0;
    w_scan_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_scan_idx = w_head + AW'(i);
      if (r_valid[w_scan_idx] && r_mem_req[w_scan_idx] && !r_data_got[w_scan_idx]) begin
        w_resp_hit = 1'b1;
        w_resp_idx = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_live_pend  = '0;
    ms_ld_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[k] && r_mem_req[k] && !r_data_got[k])
        w_live_pend = w_live_pend + PW'(1);
      if (r_valid[k] && r_rf_we[k] && r_res_from_mem[k] && !r_data_got[k] &&
          (r_waddr[k] != 5'd0) && ((r_waddr[k] == ds_rj) || (r_waddr[k] == ds_rk)))
        ms_ld_hazard = 1'b1;
    end
  end

  assign w_cancel_dec   = data_sram_data_ok && (r_cancel_cnt != '0);
  assign w_route        = data_sram_data_ok && (r_cancel_cnt == '0) && w_resp_hit;
  assign w_resp_to_head = w_route && (w_resp_idx == w_head);
  assign w_head_ready   = !r_mem_req[w_head] || r_data_got[w_head] || w_resp_to_head;

  assign ms_to_ws_valid = r_valid[w_head] && w_head_ready && !wb_ex;
  assign w_deq          = ms_to_ws_valid && ws_allowin;
  assign w_full         = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_tail == w_head);
  assign ms_allowin     = !w_full || w_deq || wb_ex;
  assign w_enq          = es_to_ms_valid && ms_allowin && !wb_ex;

  assign ms_req_allow = ({1'b0, r_cancel_cnt} + {1'b0, w_live_pend}) < (PW+1)'(DEPTH);

  // Every live outstanding request becomes a response to swallow after a flush,
  // minus whichever response is consumed in the flush cycle itself.
  assign w_cancel_sum   = {1'b0, r_cancel_cnt} + {1'b0, w_live_pend}
                        - (PW+1)'(w_cancel_dec || w_route);
  assign w_cancel_flush = (w_cancel_sum > (PW+1)'(DEPTH)) ? PW'(DEPTH) : w_cancel_sum[PW-1:0];

  assign w_head_rdata = r_data_got[w_head] ? r_rdata[w_head] : data_sram_rdata;
  assign w_shift      = w_head_rdata >> {r_result[w_head][1:0], 3'b000};

  always_comb begin
    if (r_ld_op[w_head][4])      w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
    else if (r_ld_op[w_head][3]) w_ext = {24'h0, w_shift[7:0]};
    else if (r_ld_op[w_head][2]) w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
    else if (r_ld_op[w_head][1]) w_ext = {16'h0, w_shift[15:0]};
    else                         w_ext = w_shift;
  end

  assign ms_pc       = r_pc[w_head];
  assign ms_rf_we    = r_rf_we[w_head] && r_valid[w_head];
  assign ms_rf_waddr = r_waddr[w_head];
  assign ms_rf_wdata = r_res_from_mem[w_head] ? w_ext : r_result[w_head];
  assign ms_pl       = r_pl[w_head];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cancel_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k]        <= 1'b0;
        r_pc[k]           <= '0;
        r_result[k]       <= '0;
        r_rf_we[k]        <= 1'b0;
        r_waddr[k]        <= '0;
        r_res_from_mem[k] <= 1'b0;
        r_mem_req[k]      <= 1'b0;
        r_ld_op[k]        <= '0;
        r_pl[k]           <= '0;
        r_data_got[k]     <= 1'b0;
        r_rdata[k]        <= '0;
      end
    end else if (wb_ex) begin
      r_rd_ptr     <= r_wr_ptr;
      r_cancel_cnt <= w_cancel_flush;
      for (int k = 0; k < DEPTH; k++)
        r_valid[k] <= 1'b0;
    end else begin
      if (w_cancel_dec)
        r_cancel_cnt <= r_cancel_cnt - PW'(1);
      if (w_route) begin
        r_data_got[w_resp_idx] <= 1'b1;
        r_rdata[w_resp_idx]    <= data_sram_rdata;
      end
      if (w_deq) begin
        r_valid[w_head] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      // Placed last so a simultaneous enqueue into the slot being freed wins.
      if (w_enq) begin
        r_valid[w_tail]        <= 1'b1;
        r_pc[w_tail]           <= es_pc;
        r_result[w_tail]       <= es_result;
        r_rf_we[w_tail]        <= es_rf_we;
        r_waddr[w_tail]        <= es_rf_waddr;
        r_res_from_mem[w_tail] <= es_res_from_mem;
        r_mem_req[w_tail]      <= es_mem_req;
        r_ld_op[w_tail]        <= es_ld_op;
        r_pl[w_tail]           <= es_pl;
        r_data_got[w_tail]     <= 1'b0;
        r_wr_ptr               <= r_wr_ptr + PW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_nb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage_nb : scoreboard bench for mem_stage_nb                        |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_mem_stage_nb;

  localparam int PL_W = 87;
  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     wd;
    logic [4:0]      wa;
    logic            we;
    logic [PL_W-1:0] pl;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic            es_to_ms_valid;
  logic            ms_allowin;
  logic [31:0]     es_pc;
  logic [31:0]     es_result;
  logic            es_rf_we;
  logic [4:0]      es_rf_waddr;
  logic            es_res_from_mem;
  logic            es_mem_req;
  logic [4:0]      es_ld_op;
  logic [PL_W-1:0] es_pl;
  logic            ms_req_allow;
  logic [4:0]      ds_rj;
  logic [4:0]      ds_rk;
  logic            ms_ld_hazard;
  logic            data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic            wb_ex;
  logic            ms_to_ws_valid;
  logic            ws_allowin;
  logic [31:0]     ms_pc;
  logic            ms_rf_we;
  logic [4:0]      ms_rf_waddr;
  logic [31:0]     ms_rf_wdata;
  logic [PL_W-1:0] ms_pl;

  int   vectors     = 0;
  int   miscompares = 0;
  int   outstanding = 0;
  exp_t sb[$];
  exp_t got, want;

  mem_stage_nb #(.DEPTH(2), .PL_W(PL_W)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_result(es_result), .es_rf_we(es_rf_we),
    .es_rf_waddr(es_rf_waddr), .es_res_from_mem(es_res_from_mem),
    .es_mem_req(es_mem_req), .es_ld_op(es_ld_op), .es_pl(es_pl),
    .ms_req_allow(ms_req_allow), .ds_rj(ds_rj), .ds_rk(ds_rk),
    .ms_ld_hazard(ms_ld_hazard),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_ex(wb_ex), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .ms_pl(ms_pl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [4:0] op, input logic [1:0] off,
                                      input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (op)
      LD_B:    ext = {{24{sh[7]}}, sh[7:0]};
      LD_BU:   ext = {24'h0, sh[7:0]};
      LD_H:    ext = {{16{sh[15]}}, sh[15:0]};
      LD_HU:   ext = {16'h0, sh[15:0]};
      default: ext = sh;
    endcase
  endfunction

  function automatic logic [PL_W-1:0] mkpl(input logic [31:0] pc);
    mkpl = {pc[22:0], pc, ~pc};
  endfunction

  // Retirement monitor: every WB handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      vectors++;
      got = '{pc: ms_pc, wd: ms_rf_wdata, wa: ms_rf_waddr, we: ms_rf_we, pl: ms_pl};
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL retire_unexpected actual pc=%h wdata=%h required none", ms_pc, ms_rf_wdata);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL retire pc/wdata/waddr/we actual %h/%h/%0d/%b required %h/%h/%0d/%b (pl ok=%b)",
                   got.pc, got.wd, got.wa, got.we, want.pc, want.wd, want.wa, want.we,
                   got.pl === want.pl);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [4:0] wa,
                       input logic [4:0] op, input logic mem, input logic [31:0] rd);
    bit acc = 0;
    es_pc = pc; es_result = addr; es_rf_we = 1'b1; es_rf_waddr = wa;
    es_res_from_mem = mem; es_mem_req = mem; es_ld_op = op; es_pl = mkpl(pc);
    es_to_ms_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if (ms_allowin) acc = 1;
      @(posedge clk); #1;
    end
    es_to_ms_valid = 1'b0;
    if (!acc) begin
      miscompares++;
      $display("FAIL issue_timeout pc=%h actual allowin=0 required 1", pc);
    end else begin
      sb.push_back('{pc: pc, wd: mem ? ext(op, addr[1:0], rd) : addr, wa: wa, we: 1'b1, pl: mkpl(pc)});
      if (mem) outstanding++;
    end
  endtask

  task automatic respond(input logic [31:0] rd);
    if (outstanding == 0) begin
      miscompares++;
      $display("FAIL unmatched_data_ok actual outstanding=0 required >0");
    end else outstanding--;
    data_sram_data_ok = 1'b1; data_sram_rdata = rd;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ms_allowin, ms_req_allow, ms_to_ws_valid, ms_rf_we, ms_ld_hazard} !== 5'b11000 ||
        ms_pc !== 32'h0 || ms_rf_waddr !== 5'h0 || ms_rf_wdata !== 32'h0 || ms_pl !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs actual allowin/reqallow/valid/we/haz=%b%b%b%b%b pc=%h wd=%h required 11000 pc=0 wd=0",
               ms_allowin, ms_req_allow, ms_to_ws_valid, ms_rf_we, ms_ld_hazard, ms_pc, ms_rf_wdata);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    issue(32'h100, 32'h1000, 5'd3, LD_W, 1'b1, 32'h11111111);
    issue(32'h104, 32'h1004, 5'd4, LD_W, 1'b1, 32'h22222222);
    vectors++;
    if (ms_req_allow !== 1'b0 || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_two_pending actual reqallow/allowin/valid=%b%b%b required 000",
               ms_req_allow, ms_allowin, ms_to_ws_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    respond(32'h11111111);
    respond(32'h22222222);
    drain();
    vectors++;
    if (ms_req_allow !== 1'b1 || ms_allowin !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_after_drain actual reqallow/allowin=%b%b required 11", ms_req_allow, ms_allowin);
    end
  endtask

  task automatic test_load_ext();
    issue(32'h200, 32'h2003, 5'd6, LD_B, 1'b1, 32'h80FFFF00);
    @(posedge clk); #1;
    respond(32'h80FFFF00);
    issue(32'h204, 32'h2002, 5'd7, LD_HU, 1'b1, 32'hBEEF0000);
    respond(32'hBEEF0000);
    issue(32'h208, 32'h2000, 5'd8, LD_H, 1'b1, 32'h12348001);
    respond(32'h12348001);
    issue(32'h20C, 32'h2001, 5'd9, LD_BU, 1'b1, 32'h0000A500);
    respond(32'h0000A500);
    issue(32'h210, 32'hDEADBEEF, 5'd10, 5'b00000, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_flush_cancel();
    issue(32'h400, 32'h4000, 5'd11, LD_W, 1'b1, 32'h0);
    issue(32'h404, 32'h4004, 5'd12, LD_W, 1'b1, 32'h0);
    wb_ex = 1'b1;
    #1;
    vectors++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle actual valid/allowin=%b%b required 01", ms_to_ws_valid, ms_allowin);
    end
    @(posedge clk); #1;
    wb_ex = 1'b0;
    sb.delete();
    vectors++;
    if (ms_req_allow !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cancel2 actual reqallow/valid/allowin=%b%b%b required 001",
               ms_req_allow, ms_to_ws_valid, ms_allowin);
    end
    respond(32'hBAD00001);
    vectors++;
    if (ms_req_allow !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cancel1 actual reqallow/valid=%b%b required 10", ms_req_allow, ms_to_ws_valid);
    end
    issue(32'h408, 32'h4008, 5'd13, LD_W, 1'b1, 32'h33333333);
    vectors++;
    if (ms_req_allow !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cancel1_pend1 actual reqallow=%b required 0", ms_req_allow);
    end
    respond(32'hBAD00002);
    respond(32'h33333333);
    drain();
  endtask

  task automatic test_flush_with_resp();
    issue(32'h500, 32'h5000, 5'd14, LD_W, 1'b1, 32'h0);
    issue(32'h504, 32'h5004, 5'd15, LD_W, 1'b1, 32'h0);
    wb_ex = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0BAD0;
    #1;
    vectors++;
    if (ms_to_ws_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_resp_valid actual %b required 0", ms_to_ws_valid);
    end
    @(posedge clk); #1;
    wb_ex = 1'b0; data_sram_data_ok = 1'b0;
    outstanding--;
    sb.delete();
    vectors++;
    if (ms_req_allow !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_resp_cancel1 actual reqallow=%b required 1", ms_req_allow);
    end
    issue(32'h508, 32'h5008, 5'd16, LD_W, 1'b1, 32'h44444444);
    vectors++;
    if (ms_req_allow !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_resp_pend actual reqallow=%b required 0", ms_req_allow);
    end
    respond(32'hBAD00003);
    respond(32'h44444444);
    drain();
  endtask

  task automatic test_full_enq_deq();
    ws_allowin = 1'b0;
    issue(32'h600, 32'h600A, 5'd17, 5'b00000, 1'b0, 32'h0);
    issue(32'h604, 32'h604B, 5'd18, 5'b00000, 1'b0, 32'h0);
    vectors++;
    if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_stall actual allowin/valid=%b%b required 01", ms_allowin, ms_to_ws_valid);
    end
    ws_allowin = 1'b1;
    #1;
    vectors++;
    if (ms_allowin !== 1'b1) begin
      miscompares++;
      $display("FAIL full_deq_allowin actual %b required 1", ms_allowin);
    end
    issue(32'h608, 32'h608C, 5'd19, 5'b00000, 1'b0, 32'h0);
    ws_allowin = 1'b0;
    #1;
    vectors++;
    if (ms_allowin !== 1'b0 || ms_pc !== 32'h604) begin
      miscompares++;
      $display("FAIL full_occupancy actual allowin=%b pc=%h required 0 pc=00000604", ms_allowin, ms_pc);
    end
    ws_allowin = 1'b1;
    drain();
  endtask

  task automatic test_hazard();
    ds_rj = 5'd5; ds_rk = 5'd0;
    ws_allowin = 1'b0;
    issue(32'h700, 32'h7000, 5'd5, LD_W, 1'b1, 32'h66666666);
    vectors++;
    if (ms_ld_hazard !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_rj actual %b required 1", ms_ld_hazard);
    end
    @(posedge clk); #1;
    vectors++;
    if (ms_ld_hazard !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_hold actual %b required 1", ms_ld_hazard);
    end
    respond(32'h66666666);
    vectors++;
    if (ms_ld_hazard !== 1'b0 || ms_to_ws_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_after_data actual haz/valid=%b%b required 01", ms_ld_hazard, ms_to_ws_valid);
    end
    ws_allowin = 1'b1;
    drain();
    ds_rj = 5'd9; ds_rk = 5'd7;
    issue(32'h704, 32'h7004, 5'd7, LD_W, 1'b1, 32'h77777777);
    vectors++;
    if (ms_ld_hazard !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_rk actual %b required 1", ms_ld_hazard);
    end
    respond(32'h77777777);
    drain();
    ds_rj = 5'd0; ds_rk = 5'd0;
    issue(32'h708, 32'h7008, 5'd0, LD_W, 1'b1, 32'h88888888);
    vectors++;
    if (ms_ld_hazard !== 1'b0) begin
      miscompares++;
      $display("FAIL hazard_r0 actual %b required 0", ms_ld_hazard);
    end
    respond(32'h88888888);
    drain();
  endtask

  task automatic test_reset_mid();
    issue(32'h800, 32'h8000, 5'd20, LD_W, 1'b1, 32'h0);
    resetn = 1'b0;
    #1;
    sb.delete();
    outstanding = 0;
    vectors++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_req_allow !== 1'b1 || ms_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid actual allowin/valid/reqallow=%b%b%b pc=%h required 101 pc=0",
               ms_allowin, ms_to_ws_valid, ms_req_allow, ms_pc);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD00004;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    issue(32'h804, 32'h8004, 5'd21, LD_W, 1'b1, 32'h55555555);
    respond(32'h55555555);
    drain();
  endtask

  initial begin
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_result = '0; es_rf_we = 1'b0;
    es_rf_waddr = '0; es_res_from_mem = 1'b0; es_mem_req = 1'b0; es_ld_op = '0; es_pl = '0;
    ds_rj = '0; ds_rk = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    wb_ex = 1'b0; ws_allowin = 1'b1;
    test_reset();
    test_back_to_back();
    test_load_ext();
    test_flush_cancel();
    test_flush_with_resp();
    test_full_enq_deq();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
